// File: rtl/ofmap_packer.sv
// Requantizes signed accumulator samples to int8 (round, shift, saturate) and packs four per output word.
// Optional build macro OFMAP_PACKER_RELU_EN forces negative samples to zero before rounding.
module ofmap_packer #(
    parameter int unsigned ACC_WIDTH            = 32,
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned SHIFT_WIDTH          = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [SHIFT_WIDTH-1:0]            shift,
    input  logic                              in_valid,
    input  logic [ACC_WIDTH-1:0]              in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   out_data,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] out_strb,
    output logic                              out_last,
    output logic                              sat_flag
);

    localparam int unsigned SUM_W  = ACC_WIDTH + 1;
    localparam int unsigned LANES  = C_M_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned LANE_W = 2;

    localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] Q_MIN = SUM_W'(-128);

    logic [LANE_W-1:0]           lane_cnt;
    logic [LANES-1:0][7:0]       pack_buf;
    logic [LANES-1:0]            strb_buf;

    logic [ACC_WIDTH-1:0]        acc_c;
    logic signed [SUM_W-1:0]     round_c;
    logic signed [SUM_W-1:0]     sum_c;
    logic signed [SUM_W-1:0]     q_c;
    logic [7:0]                  byte_c;
    logic                        sat_c;
    logic [LANES-1:0][7:0]       word_c;
    logic [LANES-1:0]            strb_c;
    logic                        emit_c;

    // Quantize the incoming sample: optional ReLU, round-half-up, arithmetic shift, clamp to int8.
    always_comb begin
        acc_c = in_data;
`ifdef OFMAP_PACKER_RELU_EN
        if (in_data[ACC_WIDTH-1]) begin
            acc_c = '0;
        end
`endif
        round_c = '0;
        if (shift != '0) begin
            round_c = SUM_W'(1) << (shift - SHIFT_WIDTH'(1));
        end
        sum_c  = {acc_c[ACC_WIDTH-1], acc_c} + round_c;
        q_c    = sum_c >>> shift;
        sat_c  = 1'b0;
        byte_c = q_c[7:0];
        if (q_c > Q_MAX) begin
            sat_c  = 1'b1;
            byte_c = 8'h7F;
        end else if (q_c < Q_MIN) begin
            sat_c  = 1'b1;
            byte_c = 8'h80;
        end
    end

    // Assemble the candidate output word; lanes not yet filled this word read as zero.
    always_comb begin
        word_c = '0;
        strb_c = strb_buf;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                word_c[k] = byte_c;
                strb_c[k] = 1'b1;
            end else if (strb_buf[k]) begin
                word_c[k] = pack_buf[k];
            end
        end
        emit_c = (lane_cnt == LANE_W'(LANES - 1)) || in_last;
    end

    // Packing state and registered outputs; clear drops any partial word and a concurrent sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt  <= '0;
            pack_buf  <= '0;
            strb_buf  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_strb  <= '0;
            out_last  <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            lane_cnt  <= '0;
            pack_buf  <= '0;
            strb_buf  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (sat_c) begin
                    sat_flag <= 1'b1;
                end
                if (emit_c) begin
                    out_valid <= 1'b1;
                    out_data  <= word_c;
                    out_strb  <= strb_c;
                    out_last  <= in_last;
                    lane_cnt  <= '0;
                    strb_buf  <= '0;
                end else begin
                    pack_buf[lane_cnt] <= byte_c;
                    strb_buf           <= strb_c;
                    lane_cnt           <= lane_cnt + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ofmap_packer.sv
// Randomized self-checking bench for ofmap_packer against a byte-queue reference model.
module tb_ofmap_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  shift = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_last;
    logic        sat_flag;

    int errors = 0;
    int checks = 0;

    byte         bytes_q[$];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data  = '0;
    logic [3:0]  exp_strb  = '0;
    logic        exp_last  = 1'b0;
    logic        exp_sat   = 1'b0;

    ofmap_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .shift     (shift),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_last  (out_last),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference quantizer in plain 64-bit arithmetic.
    function automatic void quant(input int d, input int sh, output byte b, output bit sat);
        longint v;
        v   = longint'(d);
        sat = 1'b0;
`ifdef OFMAP_PACKER_RELU_EN
        if (v < 0) v = 0;
`endif
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
        v = v >>> sh;
        if (v > 127) begin
            v = 127;
            sat = 1'b1;
        end else if (v < -128) begin
            v = -128;
            sat = 1'b1;
        end
        b = byte'(v);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, "_data"},  out_data,       exp_data);
        check({tag, "_strb"},  32'(out_strb),  32'(exp_strb));
        check({tag, "_last"},  32'(out_last),  32'(exp_last));
        check({tag, "_sat"},   32'(sat_flag),  32'(exp_sat));
    endtask

    // Apply one cycle of stimulus, advance the model, and compare shortly after the edge.
    task automatic step(input logic v, input int d, input logic l, input logic c, input string tag);
        byte b;
        bit  s;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        clear    = c;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        if (c) begin
            bytes_q.delete();
            exp_sat = 1'b0;
        end else if (v) begin
            quant(d, int'(shift), b, s);
            if (s) exp_sat = 1'b1;
            bytes_q.push_back(b);
            if (bytes_q.size() == 4 || l) begin
                exp_data = '0;
                for (int i = 0; i < bytes_q.size(); i++)
                    exp_data[8*i +: 8] = bytes_q[i];
                exp_strb  = 4'((1 << bytes_q.size()) - 1);
                exp_last  = l;
                exp_valid = 1'b1;
                bytes_q.delete();
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        bytes_q.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_strb  = '0;
        exp_last  = 1'b0;
        exp_sat   = 1'b0;
        check_outputs("reset_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int mode;
        int d;
        logic v;
        logic l;
        logic c;

        #1;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0, "idle");

        // Basic packing
        step(1'b1, 1, 1'b0, 1'b0, "basic");
        step(1'b1, 2, 1'b0, 1'b0, "basic");
        step(1'b1, 3, 1'b0, 1'b0, "basic");
        step(1'b1, 4, 1'b0, 1'b0, "basic");
        check("basic_word", out_data, 32'h04030201);
        check("basic_strb", 32'(out_strb), 32'hF);
        step(1'b0, 0, 1'b0, 1'b0, "basic_after");
        check("basic_pulse", 32'(out_valid), 32'h0);

        // Rounding
        shift = 5'd4;
        step(1'b0, 0, 1'b0, 1'b1, "clr");
        step(1'b1, 24, 1'b0, 1'b0, "round");
        step(1'b1, -24, 1'b1, 1'b0, "round");
`ifdef OFMAP_PACKER_RELU_EN
        check("round_word", out_data, 32'h00000002);
`else
        check("round_word", out_data, 32'h0000FF02);
`endif

        // Saturation
        shift = 5'd0;
        step(1'b0, 0, 1'b0, 1'b1, "clr");
        step(1'b1, 1000, 1'b0, 1'b0, "sat");
        check("sat_set", 32'(sat_flag), 32'h1);
        step(1'b1, -1000, 1'b1, 1'b0, "sat");
`ifdef OFMAP_PACKER_RELU_EN
        check("sat_word", out_data, 32'h0000007F);
`else
        check("sat_word", out_data, 32'h0000807F);
`endif
        step(1'b0, 0, 1'b0, 1'b1, "sat_clr");
        check("sat_cleared", 32'(sat_flag), 32'h0);

        // Partial last word
        step(1'b1, 5, 1'b0, 1'b0, "partial");
        step(1'b1, 6, 1'b1, 1'b0, "partial");
        check("partial_word", out_data, 32'h00000605);
        check("partial_strb", 32'(out_strb), 32'h3);
        check("partial_last", 32'(out_last), 32'h1);

        // Last on lane 0
        step(1'b1, 9, 1'b1, 1'b0, "lane0_last");
        check("lane0_strb", 32'(out_strb), 32'h1);

        // Clear mid-word, with a concurrent sample
        step(1'b1, 7, 1'b0, 1'b0, "clrmid");
        step(1'b1, 8, 1'b0, 1'b0, "clrmid");
        step(1'b1, 9, 1'b0, 1'b1, "clrmid");
        check("clrmid_noword", 32'(out_valid), 32'h0);
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0, "clrmid_next");
        check("clrmid_word", out_data, 32'h04030201);

        // Reset mid-word
        for (int i = 0; i < 3; i++) step(1'b1, 10 + i, 1'b0, 1'b0, "rstmid");
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 20 + i, 1'b0, 1'b0, "rstmid_next");
        check("rstmid_word", out_data, 32'h17161514);

        // Randomized layers
        for (int layer = 0; layer < 40; layer++) begin
            shift = 5'($urandom_range(0, 31));
            step(1'b0, 0, 1'b0, 1'b1, "rnd_clr");
            for (int n = 0; n < 60; n++) begin
                mode = $urandom_range(0, 3);
                case (mode)
                    0: d = int'($urandom());
                    1: d = int'($urandom_range(0, 600)) - 300;
                    2: d = int'($urandom_range(0, 1 << 20)) - (1 << 19);
                    default: d = int'($urandom_range(0, 4000)) - 2000;
                endcase
                v = ($urandom_range(0, 3) != 0);
                l = ($urandom_range(0, 7) == 0);
                c = ($urandom_range(0, 59) == 0);
                step(v, d, l, c, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
